tt_sweep_capture: RTL and testbench

- Sequential stimulus/capture stage placed directly upstream of the 7-input combinational majority-network function blocks.
- On request, it sweeps all 128 input patterns onto the function's x inputs and samples the single-bit output for each pattern.
- It assembles the 128-bit truth table, counts its ones and compares it against an expected signature.
- The classification flow uses it to certify each generated network against its target function hex.

---
 rtl/tt_sweep_capture.sv | 108 ++++++++++
 tb/tb_tt_sweep_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_capture.sv
// Sweeps all 2^N_IN input patterns onto a combinational function, captures its
// truth table, counts ones and compares against a latched expected signature.
module tt_sweep_capture #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] exp_tt,
  output logic [6:0]   x_out,
  input  logic         f_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic [7:0]   ones,
  output logic         match
);

  localparam int         DEPTH    = 1 << N_IN;
  localparam logic [6:0] LAST_IDX = 7'(DEPTH - 1);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [6:0]     idx_r;
  logic [3:0]     hold_r;
  logic [127:0]   tt_r;
  logic [127:0]   exp_r;
  logic [7:0]     ones_r;
  logic           match_r;
  logic           busy_r;
  logic           done_r;
  logic [127:0]   tt_upd_s;

  assign x_out = idx_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign tt    = tt_r;
  assign ones  = ones_r;
  assign match = match_r;

  // Table as it will look once the current pattern's bit is written, so the
  // final compare sees the bit sampled on the last edge.
  always_comb begin
    tt_upd_s        = tt_r;
    tt_upd_s[idx_r] = f_in;
  end

  // Sweep controller: pattern stepping, settle hold, capture and compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 7'd0;
      hold_r  <= 4'd0;
      tt_r    <= 128'd0;
      exp_r   <= 128'd0;
      ones_r  <= 8'd0;
      match_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            tt_r    <= 128'd0;
            ones_r  <= 8'd0;
            match_r <= 1'b0;
            exp_r   <= exp_tt;
            idx_r   <= 7'd0;
            hold_r  <= 4'd0;
          end
        end
        RUN: begin
          if (hold_r == SETTLE_C) begin
            tt_r   <= tt_upd_s;
            ones_r <= ones_r + {7'd0, f_in};
            hold_r <= 4'd0;
            if (idx_r == LAST_IDX) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              match_r <= (tt_upd_s == exp_r);
            end else begin
              idx_r <= idx_r + 7'd1;
            end
          end else begin
            hold_r <= hold_r + 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: two instances (SETTLE=1 and SETTLE=0) checked every
// cycle against a timing/arithmetic model, plus literal expectations.
module tb_tt_sweep_capture;

  localparam logic [127:0] GOLD = 128'hfeeafce8fce8e880fee8e8c0e8c0a880;
  localparam logic [127:0] AAAA = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;

  logic         clk;
  logic         rst_n;
  logic         start_a [2];
  logic [127:0] exp_a   [2];
  logic [6:0]   x_a     [2];
  logic         f_a     [2];
  logic         busy_a  [2];
  logic         done_a  [2];
  logic [127:0] tt_a    [2];
  logic [7:0]   ones_a  [2];
  logic         match_a [2];

  int           mode_a  [2];
  logic [127:0] tbl_a   [2];

  int           n_checks = 0;
  int           n_fail   = 0;

  // model state: edges since accept (-1 = nothing since reset)
  int           n_m   [2] = '{-1, -1};
  logic [127:0] tt_m  [2];
  logic [127:0] exp_m [2];

  tt_sweep_capture #(.N_IN(7), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .exp_tt(exp_a[0]),
    .x_out(x_a[0]), .f_in(f_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .tt(tt_a[0]), .ones(ones_a[0]), .match(match_a[0]));

  tt_sweep_capture #(.N_IN(7), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .exp_tt(exp_a[1]),
    .x_out(x_a[1]), .f_in(f_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .tt(tt_a[1]), .ones(ones_a[1]), .match(match_a[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int s1(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // function under test: 0 = x0, 1 = AND of all, 2 = table lookup, 3 = one, 4 = zero
  function automatic logic fmodel(input int md, input logic [6:0] x, input logic [127:0] tbl);
    case (md)
      0: return x[0];
      1: return &x;
      2: return tbl[x];
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [127:0] full_tt(input int md, input logic [127:0] tbl);
    logic [127:0] v;
    for (int i = 0; i < 128; i++) v[i] = fmodel(md, 7'(i), tbl);
    return v;
  endfunction

  function automatic int popc(input logic [127:0] v);
    int c = 0;
    for (int i = 0; i < 128; i++) c += int'(v[i]);
    return c;
  endfunction

  assign f_a[0] = fmodel(mode_a[0], x_a[0], tbl_a[0]);
  assign f_a[1] = fmodel(mode_a[1], x_a[1], tbl_a[1]);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: tracks accepts and edge counts; outputs are derived arithmetically.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) n_m[d] <= -1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (start_a[d] && !(n_m[d] >= 0 && n_m[d] < 128 * s1(d))) begin
          n_m[d]   <= 0;
          exp_m[d] <= exp_a[d];
          tt_m[d]  <= full_tt(mode_a[d], tbl_a[d]);
        end else if (n_m[d] >= 0 && n_m[d] < 128 * s1(d)) begin
          n_m[d] <= n_m[d] + 1;
        end
      end
    end
  end

  int           c_samp;
  int           c_x;
  logic [127:0] c_mask;
  logic [127:0] c_tt;
  logic         c_done;

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (n_m[d] < 0) begin
        c_samp = 0;
        c_x    = 0;
      end else begin
        c_samp = (n_m[d] / s1(d) > 128) ? 128 : n_m[d] / s1(d);
        c_x    = (n_m[d] / s1(d) > 127) ? 127 : n_m[d] / s1(d);
      end
      for (int i = 0; i < 128; i++) c_mask[i] = (i < c_samp);
      c_tt   = tt_m[d] & c_mask;
      c_done = (c_samp == 128);
      chk("cyc_x_out", 128'(x_a[d]), 128'(c_x));
      chk("cyc_busy", 128'(busy_a[d]), 128'(n_m[d] >= 0 && c_samp < 128));
      chk("cyc_done", 128'(done_a[d]), 128'(c_done));
      chk("cyc_tt", tt_a[d], c_tt);
      chk("cyc_ones", 128'(ones_a[d]), 128'(popc(c_tt)));
      chk("cyc_match", 128'(match_a[d]), 128'(c_done && (tt_m[d] == exp_m[d])));
    end
  end

  task automatic do_sweep(input int d, input int md, input logic [127:0] tbl,
                          input logic [127:0] ex, input int poke);
    int cyc;
    @(negedge clk);
    mode_a[d]  = md;
    tbl_a[d]   = tbl;
    exp_a[d]   = ex;
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    exp_a[d]   = ~ex;
    chk("accept_busy", 128'(busy_a[d]), 128'd1);
    chk("accept_done", 128'(done_a[d]), 128'd0);
    chk("accept_tt", tt_a[d], 128'd0);
    cyc = 0;
    while (!done_a[d] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_a[d] = (cyc == poke);
    end
    start_a[d] = 1'b0;
    chk("done_latency", 128'(cyc), 128'(128 * s1(d)));
  endtask

  logic [127:0] first_tt;
  logic [127:0] rtbl;
  logic [127:0] rex;
  int           wcyc;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0;
      exp_a[d]   = 128'd0;
      mode_a[d]  = 4;
      tbl_a[d]   = 128'd0;
    end
    #1;
    chk("rst_tt", tt_a[0], 128'd0);
    chk("rst_flags", 128'({busy_a[0], done_a[0], match_a[0], ones_a[0], x_a[0]}), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // x0 pattern on SETTLE=1
    do_sweep(0, 0, 128'd0, AAAA, -1);
    chk("t1_tt", tt_a[0], AAAA);
    chk("t1_ones", 128'(ones_a[0]), 128'd64);
    chk("t1_match", 128'(match_a[0]), 128'd1);

    // AND of all inputs
    do_sweep(0, 1, 128'd0, {1'b1, 127'd0}, -1);
    chk("t2_tt", tt_a[0], {1'b1, 127'd0});
    chk("t2_ones", 128'(ones_a[0]), 128'd1);
    chk("t2_match", 128'(match_a[0]), 128'd1);

    // golden network, then wrong signature
    do_sweep(0, 2, GOLD, GOLD, -1);
    chk("t3_match", 128'(match_a[0]), 128'd1);
    chk("t3_tt", tt_a[0], GOLD);
    do_sweep(0, 2, GOLD, GOLD ^ 128'd1, -1);
    chk("t3_mismatch", 128'(match_a[0]), 128'd0);
    chk("t3_tt_again", tt_a[0], GOLD);

    // constants on SETTLE=0
    do_sweep(1, 3, 128'd0, {128{1'b1}}, -1);
    chk("t4_tt_ones", tt_a[1], {128{1'b1}});
    chk("t4_ones128", 128'(ones_a[1]), 128'd128);
    do_sweep(1, 4, 128'd0, 128'd0, -1);
    chk("t4_tt_zero", tt_a[1], 128'd0);
    chk("t4_ones0", 128'(ones_a[1]), 128'd0);
    chk("t4_match0", 128'(match_a[1]), 128'd1);

    // reset mid-sweep at pattern 40
    @(negedge clk);
    mode_a[0]  = 0;
    exp_a[0]   = AAAA;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    wcyc = 0;
    while (x_a[0] != 7'd40 && wcyc < 1000) begin
      @(negedge clk);
      wcyc++;
    end
    chk("t5_reach40", 128'(x_a[0]), 128'd40);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_tt", tt_a[0], 128'd0);
    chk("t5_async_flags", 128'({busy_a[0], done_a[0], match_a[0], ones_a[0], x_a[0]}), 128'd0);
    chk("t5_async_dut1", 128'({busy_a[1], done_a[1], match_a[1], ones_a[1], x_a[1]}), 128'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_sweep(0, 0, 128'd0, AAAA, -1);
    chk("t5_clean_tt", tt_a[0], AAAA);
    chk("t5_clean_match", 128'(match_a[0]), 128'd1);

    // start during RUN ignored; restart from DONE reproduces the table
    do_sweep(0, 2, GOLD, GOLD, 10 * 2 + 1);
    first_tt = tt_a[0];
    chk("t6_tt", first_tt, GOLD);
    do_sweep(0, 2, GOLD, GOLD, -1);
    chk("t6_repeat", tt_a[0], first_tt);
    chk("t6_match", 128'(match_a[0]), 128'd1);

    // random functions on both instances
    for (int r = 0; r < 6; r++) begin
      rtbl = {$urandom, $urandom, $urandom, $urandom};
      rex  = (r % 3 == 0) ? (rtbl ^ (128'd1 << $urandom_range(127))) : rtbl;
      do_sweep(r % 2, 2, rtbl, rex, (r == 3) ? 7 : -1);
      chk("rand_tt", tt_a[r % 2], rtbl);
      chk("rand_match", 128'(match_a[r % 2]), 128'(r % 3 != 0));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
